dac_stream_bank: RTL and testbench

Buffered, rate-controlled multi-channel DAC front end: accepts packed N_DAC-sample words over an AXI-stream slave with full back-pressure, stores them in a DEPTH-word FIFO, and releases one word to all channel outputs every DIV+1 clocks. Sits between the sample-generation fabric and the per-channel DAC models. Generalises the fixed 256-bit, 16-channel, valid-gated bank with:

- parametrised channel count and sample width
- tready back-pressure
- prefill
- programmable update rate
- per-channel masking
- defined underrun behaviour and counting

---
 rtl/dac_stream_bank_if.sv | 20 ++
 rtl/dac_stream_bank.sv | 161 ++++++++++++++++
 tb/tb_dac_stream_bank.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dac_stream_bank_if.sv
// AXI-stream style sample bus carrying packed N_DAC-sample words into the DAC bank.
interface dac_stream_bank_if #(
    parameter int unsigned DATA_W = 256
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/dac_stream_bank.sv
// Buffered, rate-controlled multi-channel DAC front end: FIFO of packed sample words,
// prefill before running, one word released to all channels every div+1 clocks.
module dac_stream_bank #(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned N_DAC    = 16,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    dac_stream_bank_if.slave              s_axis,
    input  logic                          en,
    input  logic [7:0]                    div,
    input  logic [N_DAC-1:0]              ch_mask,
    input  logic                          zero_on_underrun,
    output logic [N_DAC*SAMPLE_W-1:0]     dac_code,
    output logic                          dac_update,
    output logic                          underrun,
    output logic [CNT_W-1:0]              underrun_cnt,
    output logic [$clog2(DEPTH+1)-1:0]    fifo_level
);
    localparam int unsigned DW = N_DAC * SAMPLE_W;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [PW-1:0] HALF = PW'(DEPTH / 2);

    typedef enum logic [1:0] {StIdle, StPrime, StRun} state_e;

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [DW-1:0]     mem_q [DEPTH];
    logic [DW-1:0]     mem_d [DEPTH];
    logic [DW-1:0]     dac_code_q, dac_code_d;
    logic              dac_update_q, dac_update_d;
    logic              underrun_q, underrun_d;
    logic [CNT_W-1:0]  underrun_cnt_q, underrun_cnt_d;

    logic              full, empty, push, pop, tick;
    logic [PW-1:0]     level;
    logic [DW-1:0]     src_word;

    // Wrap-bit pointers: equal means empty, MSB differing with equal index means full.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;

    assign s_axis.tready = ~full;
    assign push          = s_axis.tvalid && ~full;
    assign tick          = (state_q == StRun) && (cnt_q == div);
    // Pop decision uses registered emptiness, so a word pushed on an underrun tick stays put.
    assign pop           = tick && ~empty;

    assign dac_code     = dac_code_q;
    assign dac_update   = dac_update_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = underrun_cnt_q;
    assign fifo_level   = level;

    // FSM next state and tick counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!en) begin
            state_d = StIdle;
            cnt_d   = 8'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StPrime;
                    cnt_d   = 8'd0;
                end
                StPrime: begin
                    cnt_d = 8'd0;
                    if (level >= HALF) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    cnt_d = tick ? 8'd0 : cnt_q + 8'd1;
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    // FIFO pointers and storage.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = s_axis.tdata;
            wr_ptr_d                = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // Output codes, pulses and saturating underrun count, all updated on the tick edge.
    always_comb begin
        dac_code_d     = dac_code_q;
        dac_update_d   = 1'b0;
        underrun_d     = 1'b0;
        underrun_cnt_d = underrun_cnt_q;
        src_word       = dac_code_q;
        if (pop) begin
            src_word = mem_q[rd_ptr_q[AW-1:0]];
        end else if (zero_on_underrun) begin
            src_word = '0;
        end
        if (tick) begin
            for (int unsigned i = 0; i < N_DAC; i++) begin
                dac_code_d[i*SAMPLE_W +: SAMPLE_W] =
                    ch_mask[i] ? src_word[i*SAMPLE_W +: SAMPLE_W] : '0;
            end
            if (pop) begin
                dac_update_d = 1'b1;
            end else begin
                underrun_d = 1'b1;
                if (underrun_cnt_q != '1) begin
                    underrun_cnt_d = underrun_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // State registers; reset also wipes FIFO contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            cnt_q          <= 8'd0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            dac_code_q     <= '0;
            dac_update_q   <= 1'b0;
            underrun_q     <= 1'b0;
            underrun_cnt_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            dac_code_q     <= dac_code_d;
            dac_update_q   <= dac_update_d;
            underrun_q     <= underrun_d;
            underrun_cnt_q <= underrun_cnt_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end
endmodule

// File: tb/tb_dac_stream_bank.sv
// Directed bench for dac_stream_bank: DEPTH=4, 16 lanes of 16 bits, 2-bit underrun counter.
module tb_dac_stream_bank;
    localparam int unsigned SW = 16;
    localparam int unsigned ND = 16;
    localparam int unsigned DP = 4;
    localparam int unsigned CW = 2;
    localparam int unsigned DW = SW * ND;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     en;
    logic [7:0]               div;
    logic [ND-1:0]            ch_mask;
    logic                     zero_on_underrun;
    logic [DW-1:0]            dac_code;
    logic                     dac_update;
    logic                     underrun;
    logic [CW-1:0]            underrun_cnt;
    logic [$clog2(DP+1)-1:0]  fifo_level;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    dac_stream_bank_if #(.DATA_W(DW)) s_axis ();

    dac_stream_bank #(
        .SAMPLE_W (SW),
        .N_DAC    (ND),
        .DEPTH    (DP),
        .CNT_W    (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .s_axis           (s_axis),
        .en               (en),
        .div              (div),
        .ch_mask          (ch_mask),
        .zero_on_underrun (zero_on_underrun),
        .dac_code         (dac_code),
        .dac_update       (dac_update),
        .underrun         (underrun),
        .underrun_cnt     (underrun_cnt),
        .fifo_level       (fifo_level)
    );

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Word whose lane i holds base+i.
    function automatic logic [DW-1:0] mk(input logic [15:0] base);
        logic [DW-1:0] w;
        for (int i = 0; i < ND; i++) begin
            w[i*SW +: SW] = base + 16'(i);
        end
        return w;
    endfunction

    function automatic logic [DW-1:0] wa(input int k);
        return mk(16'(16'h1000 + 16'h0100 * k));
    endfunction

    function automatic logic [DW-1:0] ws(input int k);
        return mk(16'(16'h2000 + 16'h0010 * k));
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] w7fff;
    logic [DW-1:0] w7fff_masked;

    initial begin
        int in_idx;
        int out_idx;
        logic do_push;

        w7fff        = {ND{16'h7FFF}};
        w7fff_masked = {{8{16'h0000}}, {8{16'h7FFF}}};

        rst              = 1'b1;
        en               = 1'b0;
        div              = 8'd3;
        ch_mask          = 16'hFFFF;
        zero_on_underrun = 1'b0;
        s_axis.tvalid    = 1'b0;
        s_axis.tdata     = '0;
        step(2);
        rst = 1'b0;
        step(1);

        // Reset state
        chk("rst_code",  dac_code, '0);
        chk("rst_upd",   DW'(dac_update), DW'(0));
        chk("rst_undr",  DW'(underrun), DW'(0));
        chk("rst_ucnt",  DW'(underrun_cnt), DW'(0));
        chk("rst_lvl",   DW'(fifo_level), DW'(0));
        chk("rst_rdy",   DW'(s_axis.tready), DW'(1));

        // 1: fill FIFO while disabled
        for (int k = 0; k < 4; k++) begin
            s_axis.tvalid = 1'b1;
            s_axis.tdata  = wa(k);
            step(1);
        end
        s_axis.tvalid = 1'b0;
        chk("full_rdy", DW'(s_axis.tready), DW'(0));
        chk("full_lvl", DW'(fifo_level), DW'(4));
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = wa(9);
        step(1);
        s_axis.tvalid = 1'b0;
        chk("full_nopush_lvl", DW'(fifo_level), DW'(4));
        chk("idle_code", dac_code, '0);
        chk("idle_upd",  DW'(dac_update), DW'(0));

        // 2: prime and run at div=3
        en  = 1'b1;
        div = 8'd3;
        step(6);
        chk("run_upd0",  DW'(dac_update), DW'(1));
        chk("run_code0", dac_code, wa(0));
        chk("run_lvl0",  DW'(fifo_level), DW'(3));
        for (int k = 1; k < 4; k++) begin
            step(3);
            chk("run_gap_upd", DW'(dac_update), DW'(0));
            step(1);
            chk("run_upd",  DW'(dac_update), DW'(1));
            chk("run_code", dac_code, wa(k));
            chk("run_lvl",  DW'(fifo_level), DW'(3 - k));
        end

        // 3: underruns, hold then zero, counter saturates at 3
        for (int k = 1; k < 3; k++) begin
            step(3);
            chk("ur_gap", DW'(underrun), DW'(0));
            step(1);
            chk("ur_pulse", DW'(underrun), DW'(1));
            chk("ur_cnt",   DW'(underrun_cnt), DW'(k));
            chk("ur_hold",  dac_code, wa(3));
            chk("ur_upd",   DW'(dac_update), DW'(0));
        end
        zero_on_underrun = 1'b1;
        step(4);
        chk("ur_zero_pulse", DW'(underrun), DW'(1));
        chk("ur_zero_cnt",   DW'(underrun_cnt), DW'(3));
        chk("ur_zero_code",  dac_code, '0);
        for (int k = 0; k < 2; k++) begin
            step(4);
            chk("ur_sat_pulse", DW'(underrun), DW'(1));
            chk("ur_sat_cnt",   DW'(underrun_cnt), DW'(3));
        end

        // 4: div=0 continuous streaming
        en               = 1'b0;
        div              = 8'd0;
        zero_on_underrun = 1'b0;
        in_idx           = 0;
        out_idx          = 0;
        s_axis.tvalid    = 1'b1;
        s_axis.tdata     = ws(0);
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (cyc == 2) en = 1'b1;
            do_push = s_axis.tready;
            step(1);
            if (do_push) begin
                in_idx++;
                s_axis.tdata = ws(in_idx);
            end
            if (cyc == 3) begin
                chk("str_full_rdy", DW'(s_axis.tready), DW'(0));
            end
            if (cyc >= 4) begin
                chk("str_upd",  DW'(dac_update), DW'(1));
                chk("str_undr", DW'(underrun), DW'(0));
                chk("str_code", dac_code, ws(out_idx));
                chk("str_lvl",  DW'(fifo_level), DW'(3));
                out_idx++;
            end
        end
        s_axis.tvalid = 1'b0;
        step(3);
        en = 1'b0;
        step(2);

        // 5: channel mask
        ch_mask       = 16'h00FF;
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = w7fff;
        step(2);
        s_axis.tvalid = 1'b0;
        chk("mask_lvl_pre", DW'(fifo_level), DW'(2));
        en = 1'b1;
        step(3);
        chk("mask_upd",  DW'(dac_update), DW'(1));
        chk("mask_code", dac_code, w7fff_masked);
        chk("mask_lvl",  DW'(fifo_level), DW'(1));
        step(1);
        chk("mask_code2", dac_code, w7fff_masked);
        chk("mask_lvl2",  DW'(fifo_level), DW'(0));

        // 6: asynchronous reset mid-RUN with three words stored
        en      = 1'b0;
        ch_mask = 16'hFFFF;
        step(2);
        s_axis.tvalid = 1'b1;
        s_axis.tdata  = wa(5);
        step(3);
        s_axis.tvalid = 1'b0;
        chk("pre_rst_lvl", DW'(fifo_level), DW'(3));
        en  = 1'b1;
        div = 8'd200;
        step(2);
        chk("run_rst_lvl", DW'(fifo_level), DW'(3));
        #2;
        rst = 1'b1;
        #1;
        chk("arst_code", dac_code, '0);
        chk("arst_upd",  DW'(dac_update), DW'(0));
        chk("arst_undr", DW'(underrun), DW'(0));
        chk("arst_ucnt", DW'(underrun_cnt), DW'(0));
        chk("arst_lvl",  DW'(fifo_level), DW'(0));
        chk("arst_rdy",  DW'(s_axis.tready), DW'(1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        en  = 1'b1;
        div = 8'd0;
        step(5);
        chk("post_rst_lvl",  DW'(fifo_level), DW'(0));
        chk("post_rst_undr", DW'(underrun), DW'(0));
        chk("post_rst_ucnt", DW'(underrun_cnt), DW'(0));
        chk("post_rst_code", dac_code, '0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
